// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: tag width, mem_size encoding,
// response payload type and store lane helpers.
package dmem_responder_pkg;

    localparam int unsigned ROB_W = 5;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;
    localparam logic [1:0] MEM_SIZE_ILL  = 2'd3;

    typedef struct packed {
        logic [ROB_W-1:0] tag;
        logic             we;
        logic             err;
        logic [31:0]      rdata;
    } dmem_resp_t;

    function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            MEM_SIZE_BYTE: return 4'b0001 << offset;
            MEM_SIZE_HALF: return 4'b0011 << {offset[1], 1'b0};
            MEM_SIZE_WORD: return 4'b1111;
            default:       return 4'b0000;
        endcase
    endfunction

    // Replicate store data so every candidate lane carries the LSB-justified value.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            MEM_SIZE_BYTE: return {4{wdata[7:0]}};
            MEM_SIZE_HALF: return {2{wdata[15:0]}};
            default:       return wdata;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_resp_fifo.sv
// Response FIFO with combinational head output; pointers carry a wrap bit.
module resp_fifo #(
    parameter int unsigned DEPTH     = 4,
    parameter type         PAYLOAD_T = logic [31:0]
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  PAYLOAD_T wdata,
    input  logic     pop,
    output PAYLOAD_T rdata,
    output logic     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    PAYLOAD_T         mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: credit-gated request acceptance, inline word memory,
// fixed-latency response pipeline feeding an in-order response FIFO with bypass.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [1:0]       req_size,
    input  logic [31:0]      req_wdata,
    input  logic [ROB_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic [ROB_W-1:0] resp_tag,
    output logic             resp_we,
    output logic             resp_err
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned CRD_W = $clog2(RESP_DEPTH + 1);

    logic             accept;
    logic             deq;
    logic             addr_err;
    logic [31:0]      word_num;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       wstrb;
    logic [31:0]      wlanes;
    logic [CRD_W-1:0] credits_q;
    logic             ready_en_q;

    logic [31:0]      mem [MEM_WORDS];

    logic [LATENCY-1:0] pipe_valid_q;
    dmem_resp_t         pipe_q [LATENCY];
    dmem_resp_t         stage_in;
    dmem_resp_t         last_entry;
    logic               last_valid;

    dmem_resp_t         fifo_head;
    dmem_resp_t         head;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;

    assign accept   = req_valid && req_ready;
    assign deq      = resp_valid && resp_ready;
    assign word_num = {2'b00, req_addr[31:2]};
    assign word_idx = req_addr[IDX_W+1:2];
    assign wstrb    = byte_strobe(req_size, req_addr[1:0]);
    assign wlanes   = lane_data(req_size, req_wdata);

    // ready_en_q keeps req_ready low until the first edge after reset releases.
    assign req_ready = ready_en_q && (credits_q < CRD_W'(RESP_DEPTH));

    always_comb begin
        addr_err = 1'b0;
        case (req_size)
            MEM_SIZE_BYTE: addr_err = 1'b0;
            MEM_SIZE_HALF: addr_err = req_addr[0];
            MEM_SIZE_WORD: addr_err = |req_addr[1:0];
            default:       addr_err = 1'b1;
        endcase
        if (word_num >= 32'(MEM_WORDS)) addr_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[word_idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    always_comb begin
        stage_in.tag   = req_tag;
        stage_in.we    = req_we;
        stage_in.err   = addr_err;
        stage_in.rdata = (req_we || addr_err) ? 32'h0 : mem[word_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid_q <= '0;
            for (int s = 0; s < int'(LATENCY); s++) pipe_q[s] <= '0;
        end else begin
            pipe_valid_q[0] <= accept;
            pipe_q[0]       <= stage_in;
            for (int s = 1; s < int'(LATENCY); s++) begin
                pipe_valid_q[s] <= pipe_valid_q[s-1];
                pipe_q[s]       <= pipe_q[s-1];
            end
        end
    end

    assign last_valid = pipe_valid_q[LATENCY-1];
    assign last_entry = pipe_q[LATENCY-1];

    // With an empty FIFO the pipeline tail is presented directly; it is only
    // stored when the consumer does not take it this cycle.
    assign fifo_push = last_valid && !(fifo_empty && resp_ready);
    assign fifo_pop  = !fifo_empty && resp_ready;

    resp_fifo #(
        .DEPTH     (RESP_DEPTH),
        .PAYLOAD_T (dmem_resp_t)
    ) u_resp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (last_entry),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .empty (fifo_empty)
    );

    assign head       = fifo_empty ? last_entry : fifo_head;
    assign resp_valid = !fifo_empty || last_valid;
    assign resp_rdata = resp_valid ? head.rdata : 32'h0;
    assign resp_tag   = resp_valid ? head.tag : '0;
    assign resp_we    = resp_valid ? head.we : 1'b0;
    assign resp_err   = resp_valid ? head.err : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q  <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            case ({accept, deq})
                2'b10:   credits_q <= credits_q + CRD_W'(1);
                2'b01:   credits_q <= credits_q - CRD_W'(1);
                default: credits_q <= credits_q;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: directed scenarios plus random traffic against a byte-addressed
// memory model and an in-order expected-response queue with due cycles.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int unsigned MEM_WORDS  = 1024;
    localparam int unsigned LATENCY    = 2;
    localparam int unsigned RESP_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [31:0]      req_addr;
    logic [1:0]       req_size;
    logic [31:0]      req_wdata;
    logic [ROB_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_rdata;
    logic [ROB_W-1:0] resp_tag;
    logic             resp_we;
    logic             resp_err;

    always #5 clk = ~clk;

    dmem_responder #(
        .MEM_WORDS  (MEM_WORDS),
        .LATENCY    (LATENCY),
        .RESP_DEPTH (RESP_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_tag   (resp_tag),
        .resp_we    (resp_we),
        .resp_err   (resp_err)
    );

    typedef struct {
        logic [ROB_W-1:0] tag;
        logic             we;
        logic             err;
        logic [31:0]      rdata;
        int               due;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mbytes [MEM_WORDS*4];
    int         cycle;
    int         credits;
    bit         ready_en;
    int         n_checks;
    int         n_fail;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    function automatic void model_accept(input bit we, input logic [31:0] addr,
                                         input logic [1:0] size, input logic [31:0] wdata,
                                         input logic [ROB_W-1:0] tag);
        exp_t e;
        bit   err;
        int   a;
        int   b;
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && addr[1:0] != 2'b00) || ((addr >> 2) >= MEM_WORDS);
        e.tag   = tag;
        e.we    = we;
        e.err   = err;
        e.rdata = 32'h0;
        e.due   = cycle + int'(LATENCY);
        if (!err) begin
            a = int'(addr);
            b = a - (a % 4);
            if (we) begin
                for (int k = 0; k < (1 << size); k++) mbytes[a + k] = wdata[8*k +: 8];
            end else begin
                e.rdata = {mbytes[b+3], mbytes[b+2], mbytes[b+1], mbytes[b]};
            end
        end
        expq.push_back(e);
    endfunction

    task automatic step(input bit v, input bit we, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input logic [ROB_W-1:0] tag, input bit rr, output bit acc);
        bit exp_ready;
        bit exp_rvalid;
        bit deq;
        req_valid  = v;
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_wdata  = wdata;
        req_tag    = tag;
        resp_ready = rr;
        exp_ready  = ready_en && (credits < int'(RESP_DEPTH));
        exp_rvalid = (expq.size() > 0) && (expq[0].due <= cycle);
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("resp_valid", 32'(resp_valid), 32'(exp_rvalid));
        if (exp_rvalid) begin
            check_eq("resp_rdata", resp_rdata, expq[0].rdata);
            check_eq("resp_tag", 32'(resp_tag), 32'(expq[0].tag));
            check_eq("resp_we", 32'(resp_we), 32'(expq[0].we));
            check_eq("resp_err", 32'(resp_err), 32'(expq[0].err));
        end
        acc = v && exp_ready;
        deq = exp_rvalid && rr;
        if (deq) void'(expq.pop_front());
        if (acc) model_accept(we, addr, size, wdata, tag);
        credits = credits + int'(acc) - int'(deq);
        @(posedge clk);
        cycle++;
        ready_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input bit we, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input logic [ROB_W-1:0] tag, input bit rr);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) step(1'b1, we, addr, size, wdata, tag, rr, acc);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: request at 0x%08h never accepted", addr);
        end
    endtask

    task automatic idle(input int n, input bit rr);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 2'd2, 32'h0, '0, rr, acc);
    endtask

    task automatic do_reset();
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'h0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
        check_eq("rst_resp_rdata", resp_rdata, 32'h0);
        check_eq("rst_resp_tag", 32'(resp_tag), 32'h0);
        check_eq("rst_resp_we", 32'(resp_we), 32'h0);
        check_eq("rst_resp_err", 32'(resp_err), 32'h0);
        expq.delete();
        credits  = 0;
        ready_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit          acc;
        int          ntag;
        logic [31:0] ra;
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_wdata = '0; req_tag = '0; resp_ready = 1'b0;
        cycle = 0; credits = 0; ready_en = 1'b0; n_checks = 0; n_fail = 0;
        @(negedge clk);
        do_reset();

        // Give every word in the exercised region a known value.
        for (int i = 0; i < 32; i++) send(1'b1, 32'(i * 4), 2'd2, $urandom, 5'(i), 1'b1);
        idle(6, 1'b1);

        // Store then load on the next cycle sees the store.
        send(1'b1, 32'h10, 2'd2, 32'hDEADBEEF, 5'd1, 1'b1);
        send(1'b0, 32'h10, 2'd2, 32'h0, 5'd2, 1'b1);
        idle(6, 1'b1);

        // Byte merge into an existing word.
        send(1'b1, 32'h10, 2'd2, 32'h11223344, 5'd3, 1'b1);
        send(1'b1, 32'h13, 2'd0, 32'h000000AB, 5'd4, 1'b1);
        send(1'b0, 32'h10, 2'd2, 32'h0, 5'd5, 1'b1);
        idle(6, 1'b1);

        // Misaligned, illegal-size and out-of-range accesses.
        send(1'b1, 32'h0, 2'd2, 32'h55AA55AA, 5'd6, 1'b1);
        send(1'b0, 32'h21, 2'd1, 32'h0, 5'd7, 1'b1);
        send(1'b1, 32'h4002, 2'd2, 32'hFFFFFFFF, 5'd8, 1'b1);
        send(1'b1, 32'h4000, 2'd2, 32'hFFFFFFFF, 5'd9, 1'b1);
        send(1'b1, 32'h1, 2'd3, 32'hFFFFFFFF, 5'd10, 1'b1);
        send(1'b0, 32'h0, 2'd2, 32'h0, 5'd11, 1'b1);
        idle(6, 1'b1);

        // Back-pressure: exactly RESP_DEPTH accepts, then drain in order.
        ntag = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'(4 * i), 2'd2, 32'h0, 5'(ntag), 1'b0, acc);
            if (acc) ntag++;
        end
        idle(10, 1'b1);

        // Simultaneous accept and dequeue at credits == RESP_DEPTH-1.
        for (int i = 0; i < 3; i++) send(1'b0, 32'(8 * i), 2'd2, 32'h0, 5'(16 + i), 1'b0);
        idle(3, 1'b0);
        step(1'b1, 1'b0, 32'h20, 2'd2, 32'h0, 5'd20, 1'b1, acc);
        idle(2, 1'b0);
        idle(10, 1'b1);

        // Reset with requests in flight.
        for (int i = 0; i < 3; i++) send(1'b0, 32'(4 * i), 2'd2, 32'h0, 5'(24 + i), 1'b0);
        do_reset();
        idle(8, 1'b1);
        send(1'b0, 32'h10, 2'd2, 32'h0, 5'd30, 1'b1);
        send(1'b0, 32'h0, 2'd2, 32'h0, 5'd31, 1'b1);
        idle(6, 1'b1);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            ra = ($urandom_range(0, 15) == 0) ? (32'h1000 + 32'($urandom_range(0, 255)))
                                              : 32'($urandom_range(0, 127));
            step(($urandom_range(0, 3) != 0), 1'($urandom), ra,
                 ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                 $urandom, 5'($urandom), ($urandom_range(0, 2) != 0), acc);
        end
        idle(16, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, data memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, accept-to-response pipeline depth in cycles (legal range 1..4).
REQ-003 SHALL have parameter RESP_DEPTH, default 4, response FIFO entries (power of two, >= 2).
REQ-004 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, responder can accept.
REQ-008 SHALL have port req_we, input, 1, 1 = store and 0 = load.
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_size, input, 2, mem_size encoding: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-011 SHALL have port req_wdata, input, 32, store data, LSB-justified.
REQ-012 SHALL have port req_tag, input, ROB_W, opaque tag returned with the response.
REQ-013 SHALL have port resp_valid, output, 1, response present.
REQ-014 SHALL have port resp_ready, input, 1, consumer accepts the response.
REQ-015 SHALL have port resp_rdata, output, 32, full aligned word read; 0 for stores and errors.
REQ-016 SHALL have port resp_tag, output, ROB_W, echoed req_tag.
REQ-017 SHALL have port resp_we, output, 1, echoed req_we.
REQ-018 SHALL have port resp_err, output, 1, misaligned, size==3, or out-of-range access.

Function
REQ-019 SHALL accept a request on the cycle req_valid && req_ready is high.
REQ-020 SHALL drive req_ready = (credits < RESP_DEPTH); credits counts requests in the pipeline plus the FIFO.
REQ-021 SHALL increment credits on accept, decrement on resp_valid && resp_ready, and leave it unchanged when both occur in the same cycle.
REQ-022 SHALL flag an error when: half with addr[0]=1; word with addr[1:0]!=0; size==3; or word index addr[31:2] >= MEM_WORDS.
REQ-023 SHALL write a non-error store on the accept edge, using byte strobes from size and addr[1:0], with wdata replicated into the selected lanes.
REQ-024 SHALL NOT modify memory for an erroring store.
REQ-025 SHALL read a load's word on its accept edge, so a load accepted the cycle after a store observes that store.
REQ-026 SHALL carry each accepted request through a LATENCY-stage shift pipeline (valid, tag, we, err, rdata), then push it into the FIFO.
REQ-027 SHALL present a request accepted at cycle T on resp_valid at T+LATENCY when the FIFO is empty; this requires a FIFO bypass or a FIFO with same-cycle output.
REQ-028 SHALL return responses strictly in accept order.
REQ-029 SHALL hold resp_* stable while resp_valid && !resp_ready.
REQ-030 SHALL never overflow the FIFO, which is guaranteed by the credit rule; FIFO pointers wrap modulo RESP_DEPTH.

Reset
REQ-031 SHALL, on rst assertion, immediately clear credits, pipeline valids, and FIFO pointers, and drive req_ready=0, resp_valid=0, resp_rdata=0, resp_tag=0, resp_we=0, resp_err=0.
REQ-032 SHALL drive req_ready=1 on the first clock edge after rst deasserts.
REQ-033 SHALL discard in-flight requests on reset mid-operation.
REQ-034 SHALL NOT reset memory contents.

Structure
REQ-035 SHALL take ROB_W and the mem_size encoding constants from the shared defines package; the FIFO entry struct (tag, we, err, rdata) SHALL be defined in that package as dmem_resp_t.
REQ-036 SHALL instantiate a single sub-module, resp_fifo, parameterised by depth and payload type; the memory array SHALL be inferred inline.

Verification
REQ-037 The bench SHALL cover: store word 0xDEADBEEF to 0x10 at T, load 0x10 at T+1 -> load response at T+1+LATENCY with rdata=0xDEADBEEF, err=0.
REQ-038 The bench SHALL cover: store byte 0xAB to 0x13 over word 0x11223344 -> subsequent load of 0x10 returns 0xAB223344.
REQ-039 The bench SHALL cover: load half at 0x21 and store word at 0x4002 -> err=1, rdata=0, and memory unchanged.
REQ-040 The bench SHALL cover: resp_ready=0 with continuous requests -> exactly RESP_DEPTH accepts, then req_ready=0; asserting resp_ready -> responses emerge in order with tags 0..3.
REQ-041 The bench SHALL cover: same-cycle accept and dequeue at credits==RESP_DEPTH-1 -> credits stay at 3 and req_ready stays 1.
REQ-042 The bench SHALL cover: rst pulse with 3 requests in flight -> resp_valid=0 immediately, no stale response afterward, and previously stored data still readable.
